// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round per clock, stalling before any round whose key is not yet flagged valid.
// Latency NUMS_OF_ROUND cycles from accept to ct_valid; the result is held in DONE until ct_ready, with no overlap with the next accept.
module aes_encrypt_iter #(
    parameter int KEY_LEN       = 128,
    parameter int NUMS_OF_ROUND = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [KEY_LEN-1:0]                Secret_key,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0]  key_expan,
    input  logic [NUMS_OF_ROUND-1:0]          key_valid,
    input  logic [KEY_LEN-1:0]                plaintext,
    input  logic                              pt_valid,
    output logic                              pt_ready,
    output logic [KEY_LEN-1:0]                ciphertext,
    output logic                              ct_valid,
    input  logic                              ct_ready,
    output logic                              busy
);
    localparam int RW = $clog2(NUMS_OF_ROUND + 1);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, WAIT_KEY, ROUND, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [RW-1:0]      r_q, r_d;
    logic [KEY_LEN-1:0] st_q, st_d;
    logic [KEY_LEN-1:0] ct_q, ct_d;
    logic               ct_vld_q, ct_vld_d;
    logic               live_q;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [KEY_LEN-1:0] rk [NUMS_OF_ROUND];
    logic [7:0]         sb_b [16];
    logic [KEY_LEN-1:0] sr_w, mc_w, rnd_out;
    logic [RW-1:0]      r_m1;
    logic               last_rnd;

    for (genvar i = 0; i < NUMS_OF_ROUND; i++) begin : g_rk
        assign rk[i] = key_expan[i*KEY_LEN +: KEY_LEN];
    end

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb_b[i] = sbox(st_q[KEY_LEN-1-8*i -: 8]);
    end

    // Byte 4c+r sits in row r, column c; ShiftRows rotates row r left by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_w[KEY_LEN-1-8*(4*c+r) -: 8] = sb_b[4*((c+r)%4)+r];
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_w[KEY_LEN-1-32*c -: 8];
        assign a1 = sr_w[KEY_LEN-9-32*c -: 8];
        assign a2 = sr_w[KEY_LEN-17-32*c -: 8];
        assign a3 = sr_w[KEY_LEN-25-32*c -: 8];
        assign mc_w[KEY_LEN-1-32*c -: 32] = {
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
        };
    end

    assign r_m1     = r_q - RW'(1);
    assign last_rnd = (r_q == RW'(NUMS_OF_ROUND));
    assign rnd_out  = (last_rnd ? sr_w : mc_w) ^ rk[r_m1];

    always_comb begin
        fsm_d    = fsm_q;
        r_d      = r_q;
        st_d     = st_q;
        ct_d     = ct_q;
        ct_vld_d = ct_vld_q;
        case (fsm_q)
            IDLE: begin
                if (pt_valid && live_q) begin
                    st_d  = plaintext ^ Secret_key;
                    r_d   = RW'(1);
                    fsm_d = WAIT_KEY;
                end
            end
            WAIT_KEY, ROUND: begin
                if (key_valid[r_m1]) begin
                    st_d = rnd_out;
                    if (last_rnd) begin
                        fsm_d    = DONE;
                        ct_d     = rnd_out;
                        ct_vld_d = 1'b1;
                    end else begin
                        r_d   = r_q + RW'(1);
                        fsm_d = key_valid[r_q] ? ROUND : WAIT_KEY;
                    end
                end else begin
                    fsm_d = WAIT_KEY;
                end
            end
            DONE: begin
                if (ct_ready) begin
                    fsm_d    = IDLE;
                    ct_vld_d = 1'b0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // live_q keeps pt_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q    <= IDLE;
            r_q      <= '0;
            st_q     <= '0;
            ct_q     <= '0;
            ct_vld_q <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            r_q      <= r_d;
            st_q     <= st_d;
            ct_q     <= ct_d;
            ct_vld_q <= ct_vld_d;
            live_q   <= 1'b1;
        end
    end

    assign pt_ready   = (fsm_q == IDLE) && live_q;
    assign busy       = (fsm_q != IDLE);
    assign ciphertext = ct_q;
    assign ct_valid   = ct_vld_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Testbench for aes_encrypt_iter: FIPS-197 vectors, key stalls, backpressure, mid-block reset, back-to-back blocks.
module tb_aes_encrypt_iter;
    localparam int KL = 128;
    localparam int NR = 10;

    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [127:0] rk_b [NR] = '{
        128'ha0fafe1788542cb123a339392a6c7605, 128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b, 128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc, 128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] rk_c [NR] = '{
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41, 128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa, 128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026, 128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e, 128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [KL-1:0]     Secret_key = '0;
    logic [NR*KL-1:0]  key_expan = '0;
    logic [NR-1:0]     key_valid = '0;
    logic [KL-1:0]     plaintext = '0;
    logic              pt_valid = 1'b0;
    logic              pt_ready;
    logic [KL-1:0]     ciphertext;
    logic              ct_valid;
    logic              ct_ready = 1'b1;
    logic              busy;

    always #5 clk = ~clk;

    aes_encrypt_iter #(.KEY_LEN(KL), .NUMS_OF_ROUND(NR)) dut (
        .clk(clk), .reset(reset), .Secret_key(Secret_key), .key_expan(key_expan),
        .key_valid(key_valid), .plaintext(plaintext), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .ciphertext(ciphertext), .ct_valid(ct_valid),
        .ct_ready(ct_ready), .busy(busy)
    );

    int           tests = 0;
    int           fails = 0;
    logic [127:0] sb [$];
    logic [127:0] cur_exp = '0;
    int           cyc = 0;
    int           acc_edge = 0;
    int           last_lat = -1;
    int           ct_rises = 0;
    logic         prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on the ct handshake.
    always @(negedge clk) begin
        logic [127:0] exp_ct;
        if (pt_valid && pt_ready) begin
            sb.push_back(cur_exp);
            acc_edge = cyc + 1;
        end
        if (ct_valid && !prev_vld) begin
            ct_rises++;
            last_lat = cyc - acc_edge;
        end
        prev_vld = ct_valid;
        if (ct_valid) begin
            tests++;
            if (pt_ready !== 1'b0) begin
                fails++;
                $display("FAIL pt_ready_with_ct_valid: got %b want 0", pt_ready);
            end
        end
        if (ct_valid && ct_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_ct: got %h with no block outstanding", ciphertext);
            end else begin
                exp_ct = sb.pop_front();
                if (ciphertext !== exp_ct) begin
                    fails++;
                    $display("FAIL ciphertext: got %h want %h", ciphertext, exp_ct);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input bit use_c);
        Secret_key = use_c ? K_C : K_B;
        for (int i = 0; i < NR; i++)
            key_expan[i*KL +: KL] = use_c ? rk_c[i] : rk_b[i];
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] exp_ct);
        plaintext = pt;
        cur_exp   = exp_ct;
        pt_valid  = 1'b1;
        step();
        pt_valid  = 1'b0;
    endtask

    task automatic wait_ct(input int budget);
        int n = 0;
        @(negedge clk);
        while (ct_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (ct_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ct_timeout: ct_valid=%b after %0d cycles", ct_valid, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests += 4;
        if (pt_ready !== 1'b0) begin fails++; $display("FAIL rst_pt_ready: got %b want 0", pt_ready); end
        if (ct_valid !== 1'b0) begin fails++; $display("FAIL rst_ct_valid: got %b want 0", ct_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (ciphertext !== '0) begin fails++; $display("FAIL rst_ct: got %h want 0", ciphertext); end
        step();
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (pt_ready !== 1'b0) begin fails++; $display("FAIL rel_pt_ready_early: got %b want 0", pt_ready); end
        @(negedge clk);
        tests++;
        if (pt_ready !== 1'b1) begin fails++; $display("FAIL rel_pt_ready: got %b want 1", pt_ready); end
        step();
    endtask

    task automatic test_fips(input bit use_c);
        load_keys(use_c);
        key_valid = '1;
        ct_ready  = 1'b1;
        send(use_c ? PT_C : PT_B, use_c ? CT_C : CT_B);
        wait_ct(20);
        tests++;
        if (last_lat !== 10) begin fails++; $display("FAIL latency_%s: got %0d want 10", use_c ? "c1" : "b", last_lat); end
        step();
    endtask

    task automatic test_key_stall();
        int bad = 0;
        int rises0;
        pt_valid  = 1'b0;
        key_valid = '0;
        load_keys(1'b0);
        reset = 1'b0;
        sb.delete();
        step();
        reset = 1'b1;
        step();
        rises0 = ct_rises;
        send(PT_B, CT_B);
        for (int i = 0; i < NR; i++) begin
            repeat (5) begin
                @(negedge clk);
                if (busy !== 1'b1 || ct_valid !== 1'b0) bad++;
            end
            @(posedge clk);
            #1;
            key_valid[i] = 1'b1;
        end
        wait_ct(5);
        tests += 2;
        if (bad !== 0) begin fails++; $display("FAIL stall_busy_ct: got %0d bad cycles want 0", bad); end
        if (ct_rises !== rises0 + 1) begin fails++; $display("FAIL stall_ct_count: got %0d want %0d", ct_rises - rises0, 1); end
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] c0;
        int bad = 0;
        load_keys(1'b0);
        key_valid = '1;
        ct_ready  = 1'b0;
        send(PT_B, CT_B);
        wait_ct(20);
        c0 = ciphertext;
        for (int k = 0; k < 7; k++) begin
            if (ct_valid !== 1'b1 || ciphertext !== c0 || pt_ready !== 1'b0) bad++;
            if (k < 6) @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        @(posedge clk);
        #1;
        ct_ready = 1'b1;
        step();
        @(negedge clk);
        tests += 3;
        if (ct_valid !== 1'b0) begin fails++; $display("FAIL bp_ct_drop: got %b want 0", ct_valid); end
        if (pt_ready !== 1'b1) begin fails++; $display("FAIL bp_idle_ready: got %b want 1", pt_ready); end
        if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy: got %b want 0", busy); end
        step();
    endtask

    task automatic test_reset_mid();
        int rises0;
        load_keys(1'b0);
        key_valid = '1;
        ct_ready  = 1'b1;
        send(PT_B, CT_B);
        repeat (4) step();
        rises0 = ct_rises;
        reset = 1'b0;
        #1;
        tests += 4;
        if (ciphertext !== '0) begin fails++; $display("FAIL mid_rst_ct: got %h want 0", ciphertext); end
        if (ct_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_ct_valid: got %b want 0", ct_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (pt_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_pt_ready: got %b want 0", pt_ready); end
        sb.delete();
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (ct_rises !== rises0) begin fails++; $display("FAIL mid_rst_no_ct: got %0d pulses want 0", ct_rises - rises0); end
        load_keys(1'b1);
        send(PT_C, CT_C);
        wait_ct(20);
        tests++;
        if (last_lat !== 10) begin fails++; $display("FAIL mid_rst_next_latency: got %0d want 10", last_lat); end
        step();
    endtask

    task automatic test_back_to_back();
        int hs1;
        load_keys(1'b0);
        key_valid = '1;
        ct_ready  = 1'b1;
        plaintext = PT_B;
        cur_exp   = CT_B;
        pt_valid  = 1'b1;
        step();
        plaintext = PT_C;
        wait_ct(20);
        hs1 = cyc + 1;
        @(posedge clk);
        #1;
        load_keys(1'b1);
        cur_exp = CT_C;
        step();
        pt_valid = 1'b0;
        tests++;
        if (acc_edge !== hs1 + 1) begin fails++; $display("FAIL b2b_accept_edge: got %0d want %0d", acc_edge, hs1 + 1); end
        wait_ct(20);
        tests++;
        if (last_lat !== 10) begin fails++; $display("FAIL b2b_latency: got %0d want 10", last_lat); end
        step();
        tests++;
        if (sb.size() !== 0) begin fails++; $display("FAIL b2b_outstanding: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fips(1'b0);
        test_fips(1'b1);
        test_key_stall();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter KEY_LEN, default 128, the block and key width in bits.
REQ-002 SHALL have parameter NUMS_OF_ROUND, default 10, the number of AES rounds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Secret_key, input, KEY_LEN bits: the round-0 key (the cipher key).
REQ-006 SHALL have port key_expan, input, NUMS_OF_ROUND*KEY_LEN bits: slice i, bits [i*KEY_LEN +: KEY_LEN], is the key for round i+1.
REQ-007 SHALL have port key_valid, input, NUMS_OF_ROUND bits: bit i high means slice i of key_expan is valid.
REQ-008 SHALL have port plaintext, input, KEY_LEN bits: the input block.
REQ-009 SHALL have port pt_valid, input, 1 bit: plaintext is offered.
REQ-010 SHALL have port pt_ready, output, 1 bit: the block can accept plaintext.
REQ-011 SHALL have port ciphertext, output, KEY_LEN bits: the result block.
REQ-012 SHALL have port ct_valid, output, 1 bit: ciphertext is valid.
REQ-013 SHALL have port ct_ready, input, 1 bit: the downstream stage accepts the ciphertext.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 Byte order SHALL follow FIPS-197: bits [127:120] are byte 0, state is column-major.
REQ-016 The FSM SHALL have four states: IDLE, WAIT_KEY, ROUND, DONE.
REQ-017 pt_ready SHALL be high only in IDLE.
REQ-018 The block SHALL accept plaintext on a cycle where pt_valid and pt_ready are both high.
REQ-019 On accept: state <= plaintext XOR Secret_key, round counter r <= 1, next state WAIT_KEY.
REQ-020 In WAIT_KEY with key_valid[r-1] low, the block SHALL hold all state and stall indefinitely.
REQ-021 In WAIT_KEY with key_valid[r-1] high, the block SHALL perform round r in that same cycle and not visit ROUND separately; ROUND is the one-cycle state for each subsequent round whose key is already valid.
REQ-022 Rounds 1..NUMS_OF_ROUND-1 SHALL apply SubBytes, ShiftRows, MixColumns, then AddRoundKey with slice r-1.
REQ-023 The final round SHALL apply SubBytes, ShiftRows, then AddRoundKey, with no MixColumns.
REQ-024 The S-box SHALL be the FIPS-197 forward S-box, combinational, 16 instances.
REQ-025 After each round, r SHALL increment; if key_valid[r-1] is low for the new r, the next state SHALL be WAIT_KEY, else ROUND.
REQ-026 After round NUMS_OF_ROUND completes, the block SHALL go to DONE, register the result on ciphertext, and assert ct_valid.
REQ-027 Minimum latency with all keys valid: ct_valid SHALL rise 10 cycles after the accept edge (the edge that clocks the 10th round).
REQ-028 In DONE, ciphertext and ct_valid SHALL hold stable until ct_ready is high.
REQ-029 On ct_valid AND ct_ready, the block SHALL return to IDLE and deassert ct_valid on the next edge.
REQ-030 pt_ready SHALL NOT be high in the same cycle as ct_valid; there is no throughput overlap, so the next accept is at earliest one cycle after the ct handshake.
REQ-031 Secret_key and key_expan SHALL be sampled live each round and are required to stay stable from accept until the ct handshake; a key_valid bit falling mid-block SHALL only cause a stall.
REQ-032 pt_valid while busy SHALL be ignored.

Reset
REQ-033 reset low SHALL asynchronously force: FSM to IDLE, r = 0, internal state = 0, ciphertext = 0, ct_valid = 0, busy = 0.
REQ-034 pt_ready SHALL be 0 while reset is low and 1 from the first edge after reset is released.
REQ-035 Reset mid-operation SHALL discard the block in flight, with no ct_valid pulse.

Verification
REQ-036 FIPS-197 App. B test: Secret_key 2b7e151628aed2a6abf7158809cf4f3c with matching expanded keys, all key_valid = 1, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, ct_valid exactly 10 cycles after accept.
REQ-037 FIPS-197 App. C.1 test: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 Key stall test: key_valid bits rising one per 5 cycles from reset -> same App. B ciphertext, busy continuous, ct_valid only after key_valid[9].
REQ-039 Backpressure test: ct_ready held low 7 cycles -> ciphertext and ct_valid stable for 7 cycles, pt_ready low throughout, IDLE one cycle after ct_ready rises.
REQ-040 Reset test: reset pulsed low at round 5 -> all outputs 0 immediately, no ct_valid, and the next block (App. C.1) completes correctly.
REQ-041 Back-to-back test: pt_valid held high with two blocks -> both ciphertexts correct, second accept one cycle after the first ct handshake.
